// File: rtl/hyperbus_ctrl.sv
// HyperBus single-word transaction engine: CA phase, latency, one data word.
// Drives a word-wide PHY; DDR serialisation and pin timing live in the PHY.
module hyperbus_ctrl #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int LATENCY         = 6,
    parameter int READ_TIMEOUT    = 64,
    parameter int CS_RECOVERY     = 2
) (
    input  logic                       hbus_clk,
    input  logic                       hbus_rst,
    input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    input  logic [1:0]                 hbus_mask_i,
    input  logic                       hbus_rrq,
    input  logic                       hbus_wrq,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    output logic                       hbus_ready,
    output logic                       hbus_valid,
    output logic                       hbus_busy,
    output logic                       hbus_err,
    output logic                       phy_cs_n,
    output logic                       phy_ck_en,
    output logic [HBUS_DATA_WIDTH-1:0] phy_dq_o,
    output logic                       phy_dq_oe,
    output logic [1:0]                 phy_rwds_o,
    output logic                       phy_rwds_oe,
    input  logic                       phy_rwds_i,
    input  logic [HBUS_DATA_WIDTH-1:0] phy_dq_i,
    input  logic                       phy_dq_valid_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_WDATA,
        S_RDATA,
        S_RECOV
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] CA_LAST   = CW'(2);
    localparam logic [CW-1:0] LAT_LAST  = CW'(LATENCY - 1);
    localparam logic [CW-1:0] LAT2_LAST = CW'(2 * LATENCY - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(READ_TIMEOUT - 1);
    localparam logic [CW-1:0] REC_LAST  = CW'(CS_RECOVERY - 1);

    state_t state;
    state_t state_d;

    logic [CW-1:0]              cnt;
    logic [HBUS_ADDR_WIDTH-1:0] adr_q;
    logic [HBUS_DATA_WIDTH-1:0] dat_q;
    logic [1:0]                 mask_q;
    logic                       rd_q;
    logic                       dbl_q;

    logic [HBUS_ADDR_WIDTH-1:0] adr_sh;
    logic [31:0]                wa;
    logic [47:0]                ca;
    logic                       req;
    logic                       lat_done;
    logic                       rd_timeout;
    logic                       rd_done;
    logic                       rd_err;

    // Device addresses 16-bit words, so the byte address is halved.
    assign adr_sh = adr_q >> 1;
    assign wa     = 32'(adr_sh);
    assign ca     = {rd_q, 1'b0, 1'b1, wa[31:3], 13'd0, wa[2:0]};

    assign req        = hbus_wrq | hbus_rrq;
    assign lat_done   = (cnt == (dbl_q ? LAT2_LAST : LAT_LAST));
    assign rd_timeout = (cnt == TO_LAST);
    assign rd_done    = (state == S_RDATA) & (phy_dq_valid_i | rd_timeout);
    assign rd_err     = (state == S_RDATA) & ~phy_dq_valid_i & rd_timeout;

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        hbus_busy   = 1'b1;
        phy_cs_n    = 1'b1;
        phy_ck_en   = 1'b0;
        phy_dq_o    = '0;
        phy_dq_oe   = 1'b0;
        phy_rwds_o  = 2'b00;
        phy_rwds_oe = 1'b0;
        unique case (state)
            S_IDLE: begin
                hbus_busy = 1'b0;
                if (req) state_d = S_CA;
            end
            S_CA: begin
                phy_cs_n  = 1'b0;
                phy_ck_en = 1'b1;
                phy_dq_oe = 1'b1;
                unique case (cnt[1:0])
                    2'd0:    phy_dq_o = HBUS_DATA_WIDTH'(ca[47:32]);
                    2'd1:    phy_dq_o = HBUS_DATA_WIDTH'(ca[31:16]);
                    default: phy_dq_o = HBUS_DATA_WIDTH'(ca[15:0]);
                endcase
                if (cnt == CA_LAST) state_d = rd_q ? S_RDATA : S_LAT;
            end
            S_LAT: begin
                phy_cs_n  = 1'b0;
                phy_ck_en = 1'b1;
                if (lat_done) state_d = S_WDATA;
            end
            S_WDATA: begin
                phy_cs_n    = 1'b0;
                phy_ck_en   = 1'b1;
                phy_dq_oe   = 1'b1;
                phy_dq_o    = dat_q;
                phy_rwds_oe = 1'b1;
                phy_rwds_o  = mask_q;
                state_d     = S_RECOV;
            end
            S_RDATA: begin
                phy_cs_n  = 1'b0;
                phy_ck_en = 1'b1;
                if (rd_done) state_d = S_RECOV;
            end
            S_RECOV: begin
                if (cnt == REC_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            cnt        <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            mask_q     <= 2'b00;
            rd_q       <= 1'b0;
            dbl_q      <= 1'b0;
            hbus_dat_o <= '0;
            hbus_ready <= 1'b0;
            hbus_valid <= 1'b0;
            hbus_err   <= 1'b0;
        end else begin
            // Every state counts its own cycles from zero.
            if ((state_d != state) || (state == S_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            hbus_ready <= (state == S_WDATA);
            hbus_valid <= rd_done;
            hbus_err   <= rd_err;
            // A simultaneous write and read request resolves to the write.
            if ((state == S_IDLE) && req) begin
                adr_q  <= hbus_adr_i;
                dat_q  <= hbus_dat_i;
                mask_q <= hbus_mask_i;
                rd_q   <= ~hbus_wrq;
            end
            if ((state == S_CA) && (cnt == '0)) begin
                dbl_q <= phy_rwds_i;
            end
            if ((state == S_RDATA) && phy_dq_valid_i) begin
                hbus_dat_o <= phy_dq_i;
            end else if (rd_err) begin
                hbus_dat_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Bench for hyperbus_ctrl: constant vector table, random transactions
// against a cycle-timeline model, and a mid-transaction reset sequence.
module tb_hyperbus_ctrl;

    localparam int LAT = 6;
    localparam int TO  = 64;
    localparam int CSR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr_i = '0;
    logic [15:0] dat_i = '0;
    logic [1:0]  mask_i = '0;
    logic        rrq = 1'b0;
    logic        wrq = 1'b0;
    logic [15:0] dat_o;
    logic        ready;
    logic        valid;
    logic        busy;
    logic        err;
    logic        cs_n;
    logic        ck_en;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic [1:0]  rwds_o;
    logic        rwds_oe;
    logic        rwds_i = 1'b0;
    logic [15:0] dq_i = '0;
    logic        dq_valid = 1'b0;

    int tests = 0;
    int fails = 0;

    hyperbus_ctrl #(
        .HBUS_ADDR_WIDTH(32),
        .HBUS_DATA_WIDTH(16),
        .LATENCY(LAT),
        .READ_TIMEOUT(TO),
        .CS_RECOVERY(CSR)
    ) dut (
        .hbus_clk(clk),
        .hbus_rst(rst),
        .hbus_adr_i(adr_i),
        .hbus_dat_i(dat_i),
        .hbus_mask_i(mask_i),
        .hbus_rrq(rrq),
        .hbus_wrq(wrq),
        .hbus_dat_o(dat_o),
        .hbus_ready(ready),
        .hbus_valid(valid),
        .hbus_busy(busy),
        .hbus_err(err),
        .phy_cs_n(cs_n),
        .phy_ck_en(ck_en),
        .phy_dq_o(dq_o),
        .phy_dq_oe(dq_oe),
        .phy_rwds_o(rwds_o),
        .phy_rwds_oe(rwds_oe),
        .phy_rwds_i(rwds_i),
        .phy_dq_i(dq_i),
        .phy_dq_valid_i(dq_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          both;
        logic [31:0] adr;
        logic [15:0] dat;
        logic [1:0]  mask;
        bit          dbl;
        int          vk;
        logic [15:0] rdata;
    } txn_t;

    typedef struct {
        logic [15:0] ca0;
        logic [15:0] ca1;
        logic [15:0] ca2;
        int          wdat_cyc;
        int          ready_cyc;
        int          valid_cyc;
        bit          err;
        logic [15:0] rdat;
        int          idle_cyc;
    } plan_t;

    typedef struct {
        txn_t  t;
        plan_t p;
    } vec_t;

    function automatic txn_t mkt(bit rd, bit both, logic [31:0] adr,
                                 logic [15:0] dat, logic [1:0] mask,
                                 bit dbl, int vk, logic [15:0] rdata);
        txn_t t;
        t.rd = rd; t.both = both; t.adr = adr; t.dat = dat;
        t.mask = mask; t.dbl = dbl; t.vk = vk; t.rdata = rdata;
        return t;
    endfunction

    function automatic plan_t mkp(logic [15:0] c0, logic [15:0] c1,
                                  logic [15:0] c2, int wd, int rc, int vc,
                                  bit e, logic [15:0] rdat, int idle);
        plan_t p;
        p.ca0 = c0; p.ca1 = c1; p.ca2 = c2; p.wdat_cyc = wd;
        p.ready_cyc = rc; p.valid_cyc = vc; p.err = e; p.rdat = rdat;
        p.idle_cyc = idle;
        return p;
    endfunction

    // Timeline model: cycle numbers counted from the edge sampling the request.
    function automatic plan_t model(txn_t t);
        plan_t p;
        longint unsigned wa;
        longint unsigned ca;
        int l;
        int e;
        wa = longint'(t.adr) / 2;
        ca = (t.rd ? 64'h8000_0000_0000 : 64'h0) + 64'h2000_0000_0000
           + (wa / 8) * 65536 + (wa % 8);
        p.ca0 = 16'(ca >> 32);
        p.ca1 = 16'((ca >> 16) % 65536);
        p.ca2 = 16'(ca % 65536);
        if (!t.rd) begin
            l = t.dbl ? 2 * LAT : LAT;
            p.wdat_cyc  = 4 + l;
            p.ready_cyc = 5 + l;
            p.valid_cyc = 0;
            p.err       = 1'b0;
            p.rdat      = '0;
            p.idle_cyc  = p.ready_cyc + CSR;
        end else begin
            e = (t.vk >= 0 && t.vk < TO) ? t.vk : TO - 1;
            p.wdat_cyc  = 0;
            p.ready_cyc = 0;
            p.valid_cyc = 4 + e + 1;
            p.err       = !(t.vk >= 0 && t.vk < TO);
            p.rdat      = p.err ? 16'h0 : t.rdata;
            p.idle_cyc  = p.valid_cyc + CSR;
        end
        return p;
    endfunction

    function automatic logic [63:0] pack(logic c, logic k, logic qoe,
                                         logic [15:0] q, logic roe,
                                         logic [1:0] r, logic b, logic rd,
                                         logic v, logic er, logic [15:0] d);
        return {22'd0, c, k, qoe, q, roe, r, b, rd, v, er, d};
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic stray_req(int c, int idle);
        wrq = 1'b0;
        rrq = 1'b0;
        if (c < idle && $urandom_range(3) == 0) begin
            adr_i  = $urandom;
            dat_i  = 16'($urandom);
            mask_i = 2'($urandom);
            if ($urandom_range(1) == 1) wrq = 1'b1;
            else rrq = 1'b1;
        end
    endtask

    task automatic do_txn(txn_t t, plan_t p, int id);
        logic [63:0] exp_v;
        logic [63:0] got_v;
        logic        e_cs;
        logic        e_qoe;
        logic [15:0] e_q;
        logic        e_roe;
        logic        e_v;
        int          endc;
        adr_i  = t.adr;
        dat_i  = t.dat;
        mask_i = t.mask;
        wrq    = !t.rd;
        rrq    = t.rd | t.both;
        endc   = p.valid_cyc - 1;
        for (int c = 1; c <= p.idle_cyc; c++) begin
            @(posedge clk);
            #1;
            stray_req(c, p.idle_cyc);
            rwds_i = (c == 1) ? t.dbl : (c <= 3) ? !t.dbl : 1'($urandom);
            dq_i   = 16'($urandom);
            if (t.rd && c >= 4 && c <= endc) begin
                dq_valid = (t.vk >= 0 && c == 4 + t.vk);
                if (dq_valid) dq_i = t.rdata;
            end else begin
                dq_valid = 1'($urandom);
            end
            @(negedge clk);
            e_cs  = (c < p.idle_cyc - CSR);
            e_qoe = (c <= 3) || (c == p.wdat_cyc);
            e_q   = (c == 1) ? p.ca0 : (c == 2) ? p.ca1 : (c == 3) ? p.ca2 :
                    (c == p.wdat_cyc) ? t.dat : 16'h0;
            e_roe = (c == p.wdat_cyc);
            e_v   = (c == p.valid_cyc);
            exp_v = pack(!e_cs, e_cs, e_qoe, e_q, e_roe,
                         e_roe ? t.mask : 2'b00, c < p.idle_cyc,
                         c == p.ready_cyc, e_v, e_v && p.err,
                         e_v ? p.rdat : 16'h0);
            got_v = pack(cs_n, ck_en, dq_oe, e_qoe ? dq_o : 16'h0, rwds_oe,
                         rwds_o, busy, ready, valid, err,
                         e_v ? dat_o : 16'h0);
            chk($sformatf("txn%0d_cyc%0d", id, c), got_v, exp_v);
        end
        wrq      = 1'b0;
        rrq      = 1'b0;
        dq_valid = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int ready_seen;
        txn_t rt;

        vecs[0].t = mkt(0, 0, 32'h0000_1234, 16'hBEEF, 2'b00, 0, 0, 16'h0);
        vecs[0].p = mkp(16'h2000, 16'h0123, 16'h0002, 10, 11, 0, 0, 16'h0, 13);
        vecs[1].t = mkt(0, 0, 32'h0000_1234, 16'hBEEF, 2'b00, 1, 0, 16'h0);
        vecs[1].p = mkp(16'h2000, 16'h0123, 16'h0002, 16, 17, 0, 0, 16'h0, 19);
        vecs[2].t = mkt(0, 0, 32'h0000_1234, 16'h1111, 2'b10, 0, 0, 16'h0);
        vecs[2].p = mkp(16'h2000, 16'h0123, 16'h0002, 10, 11, 0, 0, 16'h0, 13);
        vecs[3].t = mkt(1, 0, 32'h0000_0010, 16'h0, 2'b00, 0, 5, 16'hA5A5);
        vecs[3].p = mkp(16'hA000, 16'h0001, 16'h0000, 0, 0, 10, 0, 16'hA5A5, 12);
        vecs[4].t = mkt(1, 0, 32'h0000_0010, 16'h0, 2'b00, 0, -1, 16'h0);
        vecs[4].p = mkp(16'hA000, 16'h0001, 16'h0000, 0, 0, 68, 1, 16'h0, 70);
        vecs[5].t = mkt(0, 1, 32'h0000_2468, 16'h5A5A, 2'b01, 0, 0, 16'h0);
        vecs[5].p = mkp(16'h2000, 16'h0246, 16'h0004, 10, 11, 0, 0, 16'h0, 13);
        vecs[6].t = mkt(1, 0, 32'hFFFF_FFFE, 16'h0, 2'b00, 0, 63, 16'h1357);
        vecs[6].p = mkp(16'hAFFF, 16'hFFFF, 16'h0007, 0, 0, 68, 0, 16'h1357, 70);
        vecs[7].t = mkt(1, 0, 32'h0000_0006, 16'h0, 2'b00, 1, 0, 16'h0F0F);
        vecs[7].p = mkp(16'hA000, 16'h0000, 16'h0003, 0, 0, 5, 0, 16'h0F0F, 7);

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", pack(cs_n, ck_en, dq_oe, dq_o, rwds_oe, rwds_o,
                                busy, ready, valid, err, dat_o),
            pack(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'b00,
                 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].t, vecs[i].p, i);
        end

        for (int i = 0; i < 24; i++) begin
            rt.rd    = 1'($urandom_range(1));
            rt.both  = !rt.rd && ($urandom_range(1) == 1);
            rt.adr   = $urandom;
            rt.dat   = 16'($urandom);
            rt.mask  = 2'($urandom);
            rt.dbl   = 1'($urandom_range(1));
            rt.vk    = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(63));
            rt.rdata = 16'($urandom);
            do_txn(rt, model(rt), 100 + i);
        end

        adr_i = 32'h0000_1234;
        dat_i = 16'hBEEF;
        mask_i = 2'b00;
        wrq = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            wrq = 1'b0;
            rwds_i = 1'b0;
        end
        @(negedge clk);
        chk("mid_lat_active", {62'd0, cs_n, busy}, {62'd0, 1'b0, 1'b1});
        #2 rst = 1'b1;
        #1;
        chk("async_release", {61'd0, cs_n, ck_en, busy},
            {61'd0, 1'b1, 1'b0, 1'b0});
        ready_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (ready) ready_seen++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ready || !cs_n || busy) ready_seen++;
        end
        chk("no_ready_after_abort", 64'(ready_seen), 64'd0);

        do_txn(vecs[0].t, vecs[0].p, 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog tests=%0d failed=%0d", tests, fails + 1);
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
